// File: rtl/motor_if_pkg.sv
// Shared definitions for the motor-interface clock divider: sequencer state
// encoding and default datapath/divisor limits.
package motor_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RAMP = 2'd1,
    ST_RUN  = 2'd2,
    ST_STOP = 2'd3
  } state_e;

  localparam int DEF_CNT_W     = 28;
  localparam int DEF_DIV_MIN   = 2;
  localparam int DEF_DIV_MAX   = 16;
  localparam int DEF_RAMP_STEP = 2;

endpackage

// File: rtl/div_counter_core.sv
// Period counter for a given divisor: wrap strobe, registered square wave and
// registered one-cycle tick following the last count of each period.
module div_counter_core
  import motor_if_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             run,
  input  logic [CNT_W-1:0] div,
  output logic             boundary,
  output logic             clk_out,
  output logic             tick_en
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  always_comb begin
    boundary  = run && (cnt_q == div - ONE);
    cnt_d     = '0;
    if (run && !boundary) begin
      cnt_d = cnt_q + ONE;
    end
    // High for the first div>>1 counts; odd divisors spend the extra cycle low.
    clk_out_d = run && (cnt_q < (div >> 1));
    tick_d    = boundary;
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick_en = tick_q;

endmodule

// File: rtl/clk_div_ramp_ctrl.sv
// Divider rate sequencer: config handshake, soft-start/soft-stop and bounded
// per-period divisor ramping around a div_counter_core.
module clk_div_ramp_ctrl
  import motor_if_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int DIV_MIN   = DEF_DIV_MIN,
  parameter int DIV_MAX   = DEF_DIV_MAX,
  parameter int RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_en,
  input  logic [CNT_W-1:0] cfg_div,
  output logic             clk_out,
  output logic             tick_en,
  output logic [CNT_W-1:0] cur_div,
  output logic             at_target,
  output logic             busy
);

  localparam logic [CNT_W-1:0] MIN_V  = CNT_W'(DIV_MIN);
  localparam logic [CNT_W-1:0] MAX_V  = CNT_W'(DIV_MAX);
  localparam logic [CNT_W-1:0] STEP_V = CNT_W'(RAMP_STEP);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic             at_target_q, at_target_d;
  logic [CNT_W-1:0] div_clamped, div_stepped, diff;
  logic             accept, boundary;

  assign cfg_ready = (state_q != ST_STOP);
  assign accept    = cfg_valid && cfg_ready;

  always_comb begin
    if (cfg_div < MIN_V) begin
      div_clamped = MIN_V;
    end else if (cfg_div > MAX_V) begin
      div_clamped = MAX_V;
    end else begin
      div_clamped = cfg_div;
    end
  end

  // Compare first so the subtraction never wraps; the step never overshoots.
  always_comb begin
    diff        = '0;
    div_stepped = cur_div_q;
    if (cur_div_q > target_q) begin
      diff        = cur_div_q - target_q;
      div_stepped = cur_div_q - ((diff > STEP_V) ? STEP_V : diff);
    end else if (cur_div_q < target_q) begin
      diff        = target_q - cur_div_q;
      div_stepped = cur_div_q + ((diff > STEP_V) ? STEP_V : diff);
    end
  end

  always_comb begin
    state_d   = state_q;
    cur_div_d = cur_div_q;
    target_d  = target_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && cfg_en) begin
          target_d  = div_clamped;
          cur_div_d = MAX_V;
          state_d   = ST_RAMP;
        end
      end
      default: begin
        // The boundary uses the target latched before this edge; a same-edge
        // accept only takes effect from the following boundary.
        if (boundary) begin
          cur_div_d = div_stepped;
          if (div_stepped == target_q) begin
            state_d = (state_q == ST_STOP) ? ST_IDLE : ST_RUN;
          end
        end
        if (accept) begin
          if (!cfg_en) begin
            state_d  = ST_STOP;
            target_d = MAX_V;
          end else begin
            target_d = div_clamped;
            if ((state_d == ST_RUN) && (div_clamped != cur_div_d)) begin
              state_d = ST_RAMP;
            end
          end
        end
      end
    endcase
    at_target_d = (state_d == ST_RUN) && (cur_div_d == target_d);
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cur_div_q   <= MAX_V;
      target_q    <= MAX_V;
      at_target_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_div_q   <= cur_div_d;
      target_q    <= target_d;
      at_target_q <= at_target_d;
    end
  end

  div_counter_core #(
    .CNT_W (CNT_W)
  ) u_core (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .run      (state_q != ST_IDLE),
    .div      (cur_div_q),
    .boundary (boundary),
    .clk_out  (clk_out),
    .tick_en  (tick_en)
  );

  assign cur_div   = cur_div_q;
  assign at_target = at_target_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_clk_div_ramp_ctrl.sv
// Directed bench for clk_div_ramp_ctrl with DIV_MIN=2, DIV_MAX=16, RAMP_STEP=2.
module tb_clk_div_ramp_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_n  = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic        cfg_en = 1'b0;
  logic [27:0] cfg_div = '0;
  logic        clk_out;
  logic        tick_en;
  logic [27:0] cur_div;
  logic        at_target;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  clk_div_ramp_ctrl #(
    .CNT_W     (28),
    .DIV_MIN   (2),
    .DIV_MAX   (16),
    .RAMP_STEP (2)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_en    (cfg_en),
    .cfg_div   (cfg_div),
    .clk_out   (clk_out),
    .tick_en   (tick_en),
    .cur_div   (cur_div),
    .at_target (at_target),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; samples are taken 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic send_cfg(input logic en, input int div);
    cfg_valid = 1'b1;
    cfg_en    = en;
    cfg_div   = 28'(div);
    $display("cfg valid en=%0d div=%0d ready=%0d cur_div=%0d", en, div, cfg_ready, cur_div);
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick(input string tag);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!tick_en && n < 40);
    check_eq({tag, "_tick_seen"}, tick_en, 1);
  endtask

  int ramp_up [7] = '{4, 6, 8, 10, 12, 14, 16};
  int t0;
  logic [6:0] pat;

  initial begin
    // Reset asserted between edges
    #1 rst_n = 1'b0;
    #2;
    check_eq("rst_cur_div", cur_div, 16);
    check_eq("rst_clk_out", clk_out, 0);
    check_eq("rst_tick", tick_en, 0);
    check_eq("rst_at_target", at_target, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", cfg_ready, 1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Soft-start to 8: periods 16,14,12,10
    send_cfg(1'b1, 8);
    t0 = cyc;
    check_eq("ss_cur0", cur_div, 16);
    check_eq("ss_clk0", clk_out, 0);
    check_eq("ss_busy", busy, 1);
    tick();
    check_eq("ss_clk1", clk_out, 1);
    step_to(t0 + 8);
    check_eq("ss_clk_hi_last", clk_out, 1);
    step_to(t0 + 9);
    check_eq("ss_clk_lo_first", clk_out, 0);
    step_to(t0 + 15);
    check_eq("ss_tick15", tick_en, 0);
    check_eq("ss_cur15", cur_div, 16);
    step_to(t0 + 16);
    check_eq("ss_tick16", tick_en, 1);
    check_eq("ss_cur16", cur_div, 14);
    step_to(t0 + 30);
    check_eq("ss_cur30", cur_div, 12);
    step_to(t0 + 42);
    check_eq("ss_cur42", cur_div, 10);
    step_to(t0 + 51);
    check_eq("ss_at51", at_target, 0);
    step_to(t0 + 52);
    check_eq("ss_cur52", cur_div, 8);
    check_eq("ss_at52", at_target, 1);

    // Odd divisor 7 in one step; waveform high 3, low 4
    send_cfg(1'b1, 7);
    check_eq("odd_at_pending", at_target, 0);
    wait_tick("odd");
    check_eq("odd_cur", cur_div, 7);
    check_eq("odd_at", at_target, 1);
    pat = '0;
    for (int i = 0; i < 7; i++) begin
      tick();
      pat = {pat[5:0], clk_out};
    end
    check_eq("odd_wave", pat, 7'b1110000);

    // Clamp low: 1 -> 2
    send_cfg(1'b1, 1);
    wait_tick("clo_a");
    check_eq("clo_cur5", cur_div, 5);
    check_eq("clo_at5", at_target, 0);
    wait_tick("clo_b");
    check_eq("clo_cur3", cur_div, 3);
    wait_tick("clo_c");
    check_eq("clo_cur2", cur_div, 2);
    check_eq("clo_at2", at_target, 1);

    // Clamp high: 100 -> 16
    send_cfg(1'b1, 100);
    for (int i = 0; i < 7; i++) begin
      wait_tick("chi");
      check_eq($sformatf("chi_cur%0d", i), cur_div, ramp_up[i]);
    end
    check_eq("chi_at", at_target, 1);

    // Stop while already at DIV_MAX: idle at the next boundary
    t0 = cyc;
    send_cfg(1'b0, 0);
    check_eq("stop16_ready", cfg_ready, 0);
    wait_tick("stop16");
    check_eq("stop16_len", cyc - t0, 16);
    check_eq("stop16_busy", busy, 0);
    check_eq("stop16_cur", cur_div, 16);

    // Retarget while falling through 10
    send_cfg(1'b1, 8);
    wait_tick("rt_a");
    check_eq("rt_cur14", cur_div, 14);
    wait_tick("rt_b");
    check_eq("rt_cur12", cur_div, 12);
    wait_tick("rt_c");
    check_eq("rt_cur10", cur_div, 10);
    t0 = cyc;
    send_cfg(1'b1, 12);
    wait_tick("rt_d");
    check_eq("rt_len10", cyc - t0, 10);
    check_eq("rt_cur12b", cur_div, 12);
    check_eq("rt_at", at_target, 1);
    send_cfg(1'b1, 12);
    check_eq("same_tgt_at", at_target, 1);

    // Back to 8, then soft-stop
    send_cfg(1'b1, 8);
    wait_tick("to8_a");
    check_eq("to8_cur10", cur_div, 10);
    wait_tick("to8_b");
    check_eq("to8_cur8", cur_div, 8);
    send_cfg(1'b0, 0);
    check_eq("ss_stop_ready", cfg_ready, 0);
    check_eq("ss_stop_at", at_target, 0);
    send_cfg(1'b1, 2);
    check_eq("ss_stop_ready2", cfg_ready, 0);
    wait_tick("sp_a");
    check_eq("sp_cur10", cur_div, 10);
    check_eq("sp_busy10", busy, 1);
    wait_tick("sp_b");
    check_eq("sp_cur12", cur_div, 12);
    wait_tick("sp_c");
    check_eq("sp_cur14", cur_div, 14);
    check_eq("sp_ready14", cfg_ready, 0);
    wait_tick("sp_d");
    check_eq("sp_cur16", cur_div, 16);
    check_eq("sp_busy16", busy, 0);
    check_eq("sp_ready16", cfg_ready, 1);
    tick();
    check_eq("sp_idle_clk", clk_out, 0);
    check_eq("sp_idle_tick", tick_en, 0);

    // Asynchronous reset during STOP
    send_cfg(1'b1, 4);
    send_cfg(1'b0, 0);
    check_eq("ar_pre_clk", clk_out, 1);
    check_eq("ar_pre_ready", cfg_ready, 0);
    #3 rst_n = 1'b0;
    #2;
    check_eq("ar_busy", busy, 0);
    check_eq("ar_clk", clk_out, 0);
    check_eq("ar_cur", cur_div, 16);
    check_eq("ar_ready", cfg_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    t0 = cyc;
    send_cfg(1'b1, 4);
    check_eq("ar_start_cur", cur_div, 16);
    wait_tick("ar_first");
    check_eq("ar_first_len", cyc - t0, 17);
    check_eq("ar_first_cur", cur_div, 14);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
